// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Command, arithmetic-unit and response bundle for the sequencer.
// Revision : 1.0
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_fun;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;

    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [1:0]            arith_fun;
    logic                  arith_en;
    logic [DATA_WIDTH-1:0] arith_out;
    logic                  arith_cout;
    logic                  arith_flag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_cout;
    logic                  rsp_err;

    // master: command issuer / response consumer / arithmetic unit side
    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
        output arith_out, arith_cout, arith_flag,
        input  cmd_ready, in1, in2, arith_fun, arith_en,
        input  rsp_valid, rsp_data, rsp_cout, rsp_err
    );

    // slave: the sequencer itself
    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
        input  arith_out, arith_cout, arith_flag,
        output cmd_ready, in1, in2, arith_fun, arith_en,
        output rsp_valid, rsp_data, rsp_cout, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Issues one ALU command at a time, waits for the result with a
//            timeout and returns it on a valid/ready response channel.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_MAX   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [15:0]      op_count
);
    localparam int c_CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_div0;
    logic                  w_timeout;
    logic                  w_rsp_done;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_in1;
    logic [DATA_WIDTH-1:0] r_in2;
    logic [1:0]            r_fun;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_cout;
    logic                  r_rsp_err;
    logic [15:0]           r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_timeout     = 1'b0;
        w_rsp_done    = 1'b0;
        w_div0        = (bus.cmd_fun == 2'b11) && (bus.cmd_b == '0);
        bus.cmd_ready = 1'b0;
        bus.arith_en  = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // ready is masked while reset is held even though the state is IDLE
                bus.cmd_ready = rst_n;
                w_accept      = bus.cmd_valid & rst_n;
                if (w_accept) begin
                    w_next = w_div0 ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.arith_en = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                w_timeout = !bus.arith_flag && (r_wait_cnt == c_LAST_WAIT);
                if (bus.arith_flag || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                w_rsp_done    = bus.rsp_ready;
                if (w_rsp_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_fun      <= 2'b00;
            r_rsp_data <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_in1 <= bus.cmd_a;
                r_in2 <= bus.cmd_b;
                r_fun <= bus.cmd_fun;
                if (w_div0) begin
                    r_rsp_data <= '0;
                    r_rsp_cout <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end
            if (r_state == S_WAIT) begin
                if (bus.arith_flag) begin
                    r_rsp_data <= bus.arith_out;
                    r_rsp_cout <= bus.arith_cout;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_rsp_cout <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
            if (w_rsp_done) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.in1       = r_in1;
    assign bus.in2       = r_in2;
    assign bus.arith_fun = r_fun;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_err   = r_rsp_err;
    assign op_count      = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Randomized self-checking bench with a registered ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;
    localparam int DW = 8;
    localparam int WM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] op_count;

    alu_op_sequencer_if #(.DATA_WIDTH(DW)) bus();

    alu_op_sequencer #(.DATA_WIDTH(DW), .WAIT_MAX(WM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_ops  = 16'd0;

    // Arithmetic unit: result appears unit_delay cycles after the first WAIT cycle
    int       unit_delay = 0;
    int       cnt_down;
    bit       pend_v;
    logic [8:0] pend;

    function automatic logic [8:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] fun);
        logic [15:0] p;
        case (fun)
            2'd0: return {1'b0, a} + {1'b0, b};
            2'd1: return {1'b0, a} - {1'b0, b};
            2'd2: begin p = a * b; return p[8:0]; end
            default: return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.arith_flag <= 1'b0;
            bus.arith_out  <= '0;
            bus.arith_cout <= 1'b0;
            pend_v         <= 1'b0;
        end else begin
            bus.arith_flag <= 1'b0;
            if (bus.arith_en) begin
                if (unit_delay == 0) begin
                    {bus.arith_cout, bus.arith_out} <= alu_calc(bus.in1, bus.in2, bus.arith_fun);
                    bus.arith_flag <= 1'b1;
                end else begin
                    pend     <= alu_calc(bus.in1, bus.in2, bus.arith_fun);
                    cnt_down <= unit_delay - 1;
                    pend_v   <= 1'b1;
                end
            end else if (pend_v) begin
                if (cnt_down == 0) begin
                    {bus.arith_cout, bus.arith_out} <= pend;
                    bus.arith_flag <= 1'b1;
                    pend_v         <= 1'b0;
                end else begin
                    cnt_down <= cnt_down - 1;
                end
            end
        end
    end

    // Expected response from the command and the unit's result delay
    task automatic predict(input logic [7:0] a, input logic [7:0] b, input logic [1:0] fun,
                           input int delay, output logic [7:0] d, output logic c,
                           output logic e, output int lat, output int n_en);
        logic [8:0] r;
        if (fun == 2'd3 && b == 8'd0) begin
            d = 8'd0; c = 1'b0; e = 1'b1; lat = 1; n_en = 0;
        end else if (delay >= WM) begin
            d = 8'd0; c = 1'b0; e = 1'b1; lat = 2 + WM; n_en = 1;
        end else begin
            r = alu_calc(a, b, fun);
            d = r[7:0]; c = r[8]; e = 1'b0; lat = 3 + delay; n_en = 1;
        end
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] fun,
                           input int delay, input int bp, input string tag);
        logic [7:0] ed;
        logic       ec, ee;
        int         elat, eens, cyc, en_cnt;
        predict(a, b, fun, delay, ed, ec, ee, elat, eens);
        unit_delay = delay;
        @(negedge clk);
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_fun = fun;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL %s cmd_ready: got %b expected 1", tag, bus.cmd_ready);
        else n_pass++;
        cyc = 0; en_cnt = 0;
        do begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            cyc++;
            if (bus.arith_en === 1'b1) en_cnt++;
            if (cyc == 1) begin
                n_checks++;
                if ({bus.in1, bus.in2, bus.arith_fun} !== {a, b, fun})
                    $display("FAIL %s operands: got %h/%h/%h expected %h/%h/%h", tag,
                             bus.in1, bus.in2, bus.arith_fun, a, b, fun);
                else n_pass++;
            end
        end while (bus.rsp_valid !== 1'b1 && cyc < 20);
        n_checks++;
        if (cyc != elat) $display("FAIL %s latency: got %0d expected %0d", tag, cyc, elat);
        else n_pass++;
        n_checks++;
        if (en_cnt != eens) $display("FAIL %s arith_en cycles: got %0d expected %0d", tag, en_cnt, eens);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_data, bus.rsp_cout, bus.rsp_err} !== {ed, ec, ee})
            $display("FAIL %s response: got data=%h cout=%b err=%b expected data=%h cout=%b err=%b",
                     tag, bus.rsp_data, bus.rsp_cout, bus.rsp_err, ed, ec, ee);
        else n_pass++;
        // Backpressure with a competing command that must not be taken
        repeat (bp) begin
            bus.cmd_valid = 1'b1; bus.cmd_a = ~a;
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_cout, bus.rsp_err} !==
                {1'b1, 1'b0, ed, ec, ee})
                $display("FAIL %s hold: got v=%b rdy=%b data=%h cout=%b err=%b expected v=1 rdy=0 data=%h cout=%b err=%b",
                         tag, bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_cout, bus.rsp_err, ed, ec, ee);
            else n_pass++;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        exp_ops = exp_ops + 16'd1;
        @(negedge clk);
        bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
        n_checks++;
        if (op_count !== exp_ops) $display("FAIL %s op_count: got %0d expected %0d", tag, op_count, exp_ops);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.in1} !== {1'b0, 1'b1, a})
            $display("FAIL %s post handshake: got v=%b rdy=%b in1=%h expected v=0 rdy=1 in1=%h",
                     tag, bus.rsp_valid, bus.cmd_ready, bus.in1, a);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.arith_en, bus.in1, bus.in2, bus.arith_fun,
             bus.rsp_data, bus.rsp_cout, bus.rsp_err, op_count} !== '0)
            $display("FAIL reset state: got rdy=%b v=%b en=%b in1=%h in2=%h fun=%h data=%h cout=%b err=%b cnt=%0d expected all zero",
                     bus.cmd_ready, bus.rsp_valid, bus.arith_en, bus.in1, bus.in2, bus.arith_fun,
                     bus.rsp_data, bus.rsp_cout, bus.rsp_err, op_count);
        else n_pass++;
        #16 rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_cmd(8'd200, 8'd100, 2'b00, 0, 0, "add");
    endtask

    task automatic test_sub();
        run_cmd(8'd5, 8'd7, 2'b01, 0, 0, "sub");
    endtask

    task automatic test_div0();
        run_cmd(8'd9, 8'd0, 2'b11, 0, 0, "div0");
    endtask

    task automatic test_backpressure();
        run_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)), 1, 5, "backpressure");
    endtask

    task automatic test_timeout();
        run_cmd(8'($urandom), 8'($urandom_range(1, 255)), 2'($urandom_range(0, 3)), WM, 0, "timeout");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run_cmd(a, b, 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_in_wait();
        unit_delay = 3;
        @(negedge clk);
        bus.cmd_a = 8'd33; bus.cmd_b = 8'd44; bus.cmd_fun = 2'b00; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_ops = 16'd0;
        n_checks++;
        if ({bus.rsp_valid, bus.arith_en, bus.cmd_ready, bus.in1, bus.rsp_err, op_count} !== '0)
            $display("FAIL reset_in_wait: got v=%b en=%b rdy=%b in1=%h err=%b cnt=%0d expected all zero",
                     bus.rsp_valid, bus.arith_en, bus.cmd_ready, bus.in1, bus.rsp_err, op_count);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.arith_en, op_count} !== '0)
            $display("FAIL reset_held: got v=%b en=%b cnt=%0d expected 0/0/0",
                     bus.rsp_valid, bus.arith_en, op_count);
        else n_pass++;
        rst_n = 1'b1;
        run_cmd(8'd16, 8'd16, 2'b10, 0, 0, "mul_after_reset");
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = 2'b00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_div0();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
